// File: rtl/arith_seq_ctrl.sv
// arith_seq_ctrl: one-at-a-time arithmetic sequencer between issue and writeback.
// Single-cycle ADD/SUB/INC/DEC, iterative shift-add MUL and restoring DIV.
//
//   state | meaning
//   IDLE  | waiting for a request, req_ready high
//   RUN   | MUL/DIV iterating, one step per cycle for WORD_SIZE cycles
//   DONE  | response presented, held until rsp_ready
module arith_seq_ctrl #(
  parameter int WORD_SIZE   = 19,
  parameter int OPCODE_SIZE = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [OPCODE_SIZE-1:0] req_op,
  input  logic [WORD_SIZE-1:0]   req_a,
  input  logic [WORD_SIZE-1:0]   req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WORD_SIZE-1:0]   rsp_result,
  output logic [WORD_SIZE-1:0]   rsp_remainder,
  output logic                   rsp_carry,
  output logic                   rsp_div_zero,
  output logic                   rsp_illegal,
  output logic                   busy
);

  localparam int CW = $clog2(WORD_SIZE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WORD_SIZE - 1);

  localparam logic [OPCODE_SIZE-1:0] OP_ADD = OPCODE_SIZE'(0);
  localparam logic [OPCODE_SIZE-1:0] OP_SUB = OPCODE_SIZE'(1);
  localparam logic [OPCODE_SIZE-1:0] OP_MUL = OPCODE_SIZE'(2);
  localparam logic [OPCODE_SIZE-1:0] OP_DIV = OPCODE_SIZE'(3);
  localparam logic [OPCODE_SIZE-1:0] OP_INC = OPCODE_SIZE'(4);
  localparam logic [OPCODE_SIZE-1:0] OP_DEC = OPCODE_SIZE'(5);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [OPCODE_SIZE-1:0] r_op;
  logic [WORD_SIZE-1:0]   r_b;
  logic [WORD_SIZE-1:0]   r_hi;   // MUL: product high half; DIV: partial remainder
  logic [WORD_SIZE-1:0]   r_lo;   // MUL: multiplier/product low; DIV: dividend/quotient
  logic [CW-1:0]          r_cnt;

  logic [WORD_SIZE-1:0]   r_rsp_result;
  logic [WORD_SIZE-1:0]   r_rsp_rem;
  logic                   r_rsp_carry;
  logic                   r_rsp_dz;
  logic                   r_rsp_ill;

  logic                   w_accept;
  logic                   w_long_op;
  logic [WORD_SIZE-1:0]   w_b_eff;
  logic [WORD_SIZE:0]     w_sum;
  logic [WORD_SIZE-1:0]   w_diff;
  logic [WORD_SIZE-1:0]   w_fast_result;
  logic [WORD_SIZE-1:0]   w_fast_rem;
  logic                   w_fast_carry;
  logic                   w_fast_dz;
  logic                   w_fast_ill;

  logic [WORD_SIZE:0]     w_mul_sum;
  logic [WORD_SIZE:0]     w_div_shift;
  logic [WORD_SIZE:0]     w_div_diff;
  logic                   w_div_ge;
  logic [WORD_SIZE-1:0]   w_hi_nxt;
  logic [WORD_SIZE-1:0]   w_lo_nxt;

  assign w_accept  = req_valid && (r_state == S_IDLE);
  assign w_long_op = (req_op == OP_MUL) || ((req_op == OP_DIV) && (req_b != '0));

  // Single-cycle results computed straight from the request inputs
  always_comb begin
    w_b_eff       = ((req_op == OP_INC) || (req_op == OP_DEC)) ? WORD_SIZE'(1) : req_b;
    w_sum         = {1'b0, req_a} + {1'b0, w_b_eff};
    w_diff        = req_a - w_b_eff;
    w_fast_result = '0;
    w_fast_rem    = '0;
    w_fast_carry  = 1'b0;
    w_fast_dz     = 1'b0;
    w_fast_ill    = 1'b0;
    case (req_op)
      OP_ADD, OP_INC: begin
        w_fast_result = w_sum[WORD_SIZE-1:0];
        w_fast_carry  = w_sum[WORD_SIZE];
      end
      OP_SUB, OP_DEC: begin
        w_fast_result = w_diff;
        w_fast_carry  = (req_a < w_b_eff);
      end
      OP_DIV: begin
        w_fast_result = '1;
        w_fast_rem    = req_a;
        w_fast_dz     = 1'b1;
      end
      OP_MUL: ;
      default: w_fast_ill = 1'b1;
    endcase
  end

  // One MUL or DIV iteration; the sign of the trial subtraction picks the quotient bit
  always_comb begin
    w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_div_shift = {r_hi, r_lo[WORD_SIZE-1]};
    w_div_diff  = w_div_shift - {1'b0, r_b};
    w_div_ge    = !w_div_diff[WORD_SIZE];
    if (r_op == OP_MUL) begin
      w_hi_nxt = w_mul_sum[WORD_SIZE:1];
      w_lo_nxt = {w_mul_sum[0], r_lo[WORD_SIZE-1:1]};
    end else begin
      w_hi_nxt = w_div_ge ? w_div_diff[WORD_SIZE-1:0] : w_div_shift[WORD_SIZE-1:0];
      w_lo_nxt = {r_lo[WORD_SIZE-2:0], w_div_ge};
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_long_op ? S_RUN : S_DONE;
      S_RUN:  if (r_cnt == CNT_LAST) w_state_nxt = S_DONE;
      S_DONE: if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; response data comes from registers
  always_comb begin
    req_ready     = (r_state == S_IDLE);
    busy          = (r_state != S_IDLE);
    rsp_valid     = (r_state == S_DONE);
    rsp_result    = r_rsp_result;
    rsp_remainder = r_rsp_rem;
    rsp_carry     = r_rsp_carry;
    rsp_div_zero  = r_rsp_dz;
    rsp_illegal   = r_rsp_ill;
  end

  // Operand capture, iteration datapath and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op         <= '0;
      r_b          <= '0;
      r_hi         <= '0;
      r_lo         <= '0;
      r_cnt        <= '0;
      r_rsp_result <= '0;
      r_rsp_rem    <= '0;
      r_rsp_carry  <= 1'b0;
      r_rsp_dz     <= 1'b0;
      r_rsp_ill    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op  <= req_op;
          r_b   <= req_b;
          r_lo  <= req_a;
          r_hi  <= '0;
          r_cnt <= '0;
          if (!w_long_op) begin
            r_rsp_result <= w_fast_result;
            r_rsp_rem    <= w_fast_rem;
            r_rsp_carry  <= w_fast_carry;
            r_rsp_dz     <= w_fast_dz;
            r_rsp_ill    <= w_fast_ill;
          end
        end
        S_RUN: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CNT_LAST) begin
            r_rsp_result <= w_lo_nxt;
            r_rsp_rem    <= (r_op == OP_MUL) ? '0 : w_hi_nxt;
            r_rsp_carry  <= (r_op == OP_MUL) ? (|w_hi_nxt) : 1'b0;
            r_rsp_dz     <= 1'b0;
            r_rsp_ill    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arith_seq_ctrl.sv
// Self-checking bench for arith_seq_ctrl: directed vectors, randomized ops
// against an arithmetic reference model, backpressure and mid-run reset.
module tb_arith_seq_ctrl;
  localparam int W = 19;
  localparam longint MASK = (64'd1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready;
  logic [4:0]   req_op;
  logic [W-1:0] req_a, req_b;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_result, rsp_remainder;
  logic         rsp_carry, rsp_div_zero, rsp_illegal, busy;

  arith_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_remainder(rsp_remainder),
    .rsp_carry(rsp_carry), .rsp_div_zero(rsp_div_zero),
    .rsp_illegal(rsp_illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a, b;
    logic [W-1:0] res, rem;
    logic         carry, dz, ill;
    int           lat;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference behaviour from plain integer arithmetic
  function automatic vec_t model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    vec_t   v;
    longint la, lb, t;
    la = longint'(a);
    lb = longint'(b);
    v.op = op; v.a = a; v.b = b;
    v.res = '0; v.rem = '0; v.carry = 0; v.dz = 0; v.ill = 0; v.lat = 1;
    case (op)
      0, 4: begin
        t = la + ((op == 4) ? 1 : lb);
        v.res = W'(t & MASK); v.carry = (t > MASK);
      end
      1, 5: begin
        t = (op == 5) ? 1 : lb;
        v.res = W'((la - t) & MASK); v.carry = (la < t);
      end
      2: begin
        t = la * lb;
        v.res = W'(t & MASK); v.carry = ((t >> W) != 0); v.lat = W + 1;
      end
      3: begin
        if (lb == 0) begin
          v.res = W'(MASK); v.rem = a; v.dz = 1;
        end else begin
          v.res = W'(la / lb); v.rem = W'(la % lb); v.lat = W + 1;
        end
      end
      default: v.ill = 1;
    endcase
    return v;
  endfunction

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_rsp(input string tag, input vec_t v);
    check({tag, " result"},   rsp_result,    v.res);
    check({tag, " remainder"}, rsp_remainder, v.rem);
    check({tag, " carry"},    rsp_carry,     v.carry);
    check({tag, " div_zero"}, rsp_div_zero,  v.dz);
    check({tag, " illegal"},  rsp_illegal,   v.ill);
  endtask

  // Issue one request, scramble inputs after accept, measure latency, check, retire
  task automatic run_op(input string tag, input vec_t v);
    int lat;
    @(negedge clk);
    check({tag, " req_ready"}, req_ready, 1);
    req_valid = 1; req_op = v.op; req_a = v.a; req_b = v.b;
    @(posedge clk); #1;
    req_valid = 0;
    req_op = 5'($urandom); req_a = W'($urandom); req_b = W'($urandom);
    wait_rsp(lat);
    check({tag, " latency"}, lat, v.lat);
    check_rsp(tag, v);
    @(negedge clk); rsp_ready = 1;
    @(posedge clk); #1;
    check({tag, " rsp_valid after handshake"}, rsp_valid, 0);
    @(negedge clk); rsp_ready = 0;
  endtask

  vec_t vecs[$];
  vec_t v;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int           lat;
    logic [4:0]   op;
    logic [W-1:0] a, b;

    rst = 1; req_valid = 0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset rsp_valid", rsp_valid, 0);
    check("reset req_ready", req_ready, 1);
    check("reset busy", busy, 0);
    check("reset result", rsp_result, 0);
    check("reset flags", {rsp_carry, rsp_div_zero, rsp_illegal}, 0);
    @(negedge clk); rst = 0;

    // op, a, b, result, remainder, carry, div_zero, illegal, latency
    vecs.push_back('{5'd0, 19'h7FFFF, 19'h00001, 19'h00000, 19'd0,    1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{5'd1, 19'd5,     19'd7,     19'h7FFFE, 19'd0,    1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{5'd1, 19'd7,     19'd5,     19'd2,     19'd0,    1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{5'd5, 19'd0,     19'd123,   19'h7FFFF, 19'd0,    1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{5'd4, 19'h7FFFF, 19'd77,    19'h00000, 19'd0,    1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{5'd2, 19'd300,   19'd500,   19'h249F0, 19'd0,    1'b0, 1'b0, 1'b0, 20});
    vecs.push_back('{5'd2, 19'd1024,  19'd1024,  19'd0,     19'd0,    1'b1, 1'b0, 1'b0, 20});
    vecs.push_back('{5'd2, 19'h7FFFF, 19'h7FFFF, 19'd1,     19'd0,    1'b1, 1'b0, 1'b0, 20});
    vecs.push_back('{5'd3, 19'd100000, 19'd7,    19'd14285, 19'd5,    1'b0, 1'b0, 1'b0, 20});
    vecs.push_back('{5'd3, 19'd5,     19'd9,     19'd0,     19'd5,    1'b0, 1'b0, 1'b0, 20});
    vecs.push_back('{5'd3, 19'd1234,  19'd0,     19'h7FFFF, 19'd1234, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{5'd31, 19'd99,   19'd42,    19'd0,     19'd0,    1'b0, 1'b0, 1'b1, 1});
    foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i]);

    // Backpressure: response held for 5 cycles while another request waits
    @(negedge clk);
    req_valid = 1; req_op = 5'd2; req_a = 19'd300; req_b = 19'd500;
    @(posedge clk); #1;
    req_valid = 0;
    wait_rsp(lat);
    check("bp mul latency", lat, 20);
    @(negedge clk);
    req_valid = 1; req_op = 5'd0; req_a = 19'd10; req_b = 19'd20;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp rsp_valid held", rsp_valid, 1);
      check("bp result held", rsp_result, 19'h249F0);
      check("bp carry held", rsp_carry, 0);
      check("bp req_ready low", req_ready, 0);
    end
    @(negedge clk); rsp_ready = 1;
    @(posedge clk); #1;
    check("bp rsp_valid dropped", rsp_valid, 0);
    check("bp idle req_ready", req_ready, 1);
    @(negedge clk); rsp_ready = 0;
    @(posedge clk); #1;
    req_valid = 0;
    check("bp pending accepted", rsp_valid, 1);
    check("bp pending result", rsp_result, 30);
    @(negedge clk); rsp_ready = 1;
    @(posedge clk); #1;
    @(negedge clk); rsp_ready = 0;

    // Reset during MUL iteration 10 aborts with no response
    @(negedge clk);
    req_valid = 1; req_op = 5'd2; req_a = 19'd1024; req_b = 19'd1024;
    @(posedge clk); #1;
    req_valid = 0;
    repeat (10) @(posedge clk);
    #2 rst = 1;
    #1;
    check("abort rsp_valid", rsp_valid, 0);
    check("abort busy", busy, 0);
    check("abort result", rsp_result, 0);
    check("abort carry", rsp_carry, 0);
    @(negedge clk); rst = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) check("abort no late response", rsp_valid, 0);
    end
    check("abort idle after release", busy, 0);
    run_op("post-reset add", model(5'd0, 19'd2, 19'd3));

    // Randomized ops against the reference model
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 7))
        6:       op = 5'($urandom_range(6, 31));
        7:       op = 5'd3;
        default: op = 5'($urandom_range(0, 5));
      endcase
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom_range(0, 3) == 0 ? $urandom_range(1, 300) : $urandom);
      run_op($sformatf("rand%0d op%0d", i, op), model(op, a, b));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
